// File: rtl/avr_sram_seq_if.sv
// AVR command port and SRAM strobe/address bus of the AVR<->SRAM sequencer.
// The sequencer connects through slave; the AVR/SRAM side drives master.
interface avr_sram_seq_if #(
  parameter int unsigned AWIDTH = 24,
  parameter int unsigned DWIDTH = 8
);
  logic [1:0]        avr_sel;
  logic              avr_wr;
  logic              avr_rd;
  logic [DWIDTH-1:0] avr_din;
  logic [DWIDTH-1:0] avr_dout;
  logic              busy;
  logic [AWIDTH-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic [DWIDTH-1:0] sram_dout;
  logic [DWIDTH-1:0] sram_din;

  modport slave (
    input  avr_sel, avr_wr, avr_rd, avr_din, sram_din,
    output avr_dout, busy, sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_dout
  );

  modport master (
    output avr_sel, avr_wr, avr_rd, avr_din, sram_din,
    input  avr_dout, busy, sram_addr, sram_ce_n, sram_we_n, sram_oe_n, sram_dout
  );
endinterface

// File: rtl/avr_sram_seq.sv
// AVR command sequencer: byte-wide address registers plus timed SRAM
// ce/we/oe strobes for single-byte data accesses with address auto-increment.
module avr_sram_seq #(
  parameter int unsigned AWIDTH    = 24,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned WE_CYCLES = 3,
  parameter int unsigned OE_CYCLES = 3,
  parameter int unsigned AUTOINC   = 1
) (
  input logic           clk,
  input logic           reset,
  avr_sram_seq_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam int unsigned HW = AWIDTH - 16;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] rdata;
  logic [DWIDTH-1:0] wdata;
  logic              is_read;
  logic [CW-1:0]     cnt;
  logic              busy_q;
  logic              ce_n_q;
  logic              we_n_q;
  logic              oe_n_q;

  // Sequencer; commands are only honoured in IDLE, so addr/wdata stay stable mid-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      rdata   <= '0;
      wdata   <= '0;
      is_read <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.avr_wr) begin
            case (bus.avr_sel)
              2'd0: addr[7:0]         <= bus.avr_din;
              2'd1: addr[15:8]        <= bus.avr_din;
              2'd2: addr[AWIDTH-1:16] <= bus.avr_din[HW-1:0];
              default: begin
                wdata   <= bus.avr_din;
                is_read <= 1'b0;
                state   <= SETUP;
                busy_q  <= 1'b1;
                ce_n_q  <= 1'b0;
              end
            endcase
          end else if (bus.avr_rd && bus.avr_sel == 2'd3) begin
            is_read <= 1'b1;
            state   <= SETUP;
            busy_q  <= 1'b1;
            ce_n_q  <= 1'b0;
          end
        end
        SETUP: begin
          state <= STROBE;
          if (is_read) begin
            oe_n_q <= 1'b0;
            cnt    <= CW'(OE_CYCLES - 1);
          end else begin
            we_n_q <= 1'b0;
            cnt    <= CW'(WE_CYCLES - 1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state  <= HOLD;
            we_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            if (is_read) rdata <= bus.sram_din;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          ce_n_q <= 1'b1;
          if (AUTOINC != 0) addr <= addr + AWIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readback mux; the high address byte is zero-extended for narrow AWIDTH.
  always_comb begin
    bus.avr_dout = '0;
    case (bus.avr_sel)
      2'd0:    bus.avr_dout = addr[7:0];
      2'd1:    bus.avr_dout = addr[15:8];
      2'd2:    bus.avr_dout = DWIDTH'(addr[AWIDTH-1:16]);
      default: bus.avr_dout = rdata;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.sram_addr = addr;
  assign bus.sram_ce_n = ce_n_q;
  assign bus.sram_we_n = we_n_q;
  assign bus.sram_oe_n = oe_n_q;
  assign bus.sram_dout = wdata;

  strobe_exclusive: assert property (@(posedge clk) disable iff (reset) !(!we_n_q && !oe_n_q));

endmodule

// File: doc/avr_sram_seq.md
Name: avr_sram_seq

Overview:
- Command/sequencer stage directly upstream of the CPLD AVR<->SRAM data-bus arbiter.
- The AVR writes a byte-wide address (up to 3 bytes) and then issues single-byte DATA write or read commands.
- The block generates timed active-low SRAM chip-enable, write-enable and output-enable strobes and drives the SRAM address. These strobes feed the arbiter's we/oe inputs.
- The address auto-increments after every data access, so bulk ROM uploads and readback need one AVR strobe per byte.

Parameters:
- AWIDTH, 24, SRAM address width; legal range 17..24; bits above AWIDTH written via ADDR_H are discarded.
- DWIDTH, 8, data width; fixed at 8.
- WE_CYCLES, 3, clk cycles sram_we_n is held low per write; legal range 1..15.
- OE_CYCLES, 3, clk cycles sram_oe_n is held low per read; legal range 1..15.
- AUTOINC, 1, 1 = increment address after each DATA access; 0 = address held.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- avr_sel  input  2  register select: 0=ADDR_L, 1=ADDR_M, 2=ADDR_H, 3=DATA.
- avr_wr  input  1  one-cycle write command pulse, already synchronous to clk.
- avr_rd  input  1  one-cycle read command pulse, already synchronous to clk.
- avr_din  input  DWIDTH  data from AVR.
- avr_dout  output  DWIDTH  readback, combinational mux of internal registers by avr_sel.
- busy  output  1  high while an SRAM cycle is in progress.
- sram_addr  output  AWIDTH  SRAM address (address register).
- sram_ce_n  output  1  SRAM chip enable, active low.
- sram_we_n  output  1  write strobe to arbiter/SRAM, active low.
- sram_oe_n  output  1  read strobe to arbiter/SRAM, active low.
- sram_dout  output  DWIDTH  write data toward SRAM.
- sram_din  input  DWIDTH  read data from SRAM.

Behaviour:
- **Reset.** Synchronous, active-high: clk and reset only; reset is sampled on the rising edge of clk.
- **Reset values.**
  - State IDLE, addr=0, rdata=0, sram_dout=0, busy=0.
  - sram_ce_n=1, sram_we_n=1, sram_oe_n=1.
  - Reset mid-cycle aborts the access: strobes deassert at that edge and there is no increment.
- **Registered outputs.** All outputs except avr_dout are registered.
- **Readback (avr_dout).**
  - sel0 = addr[7:0], sel1 = addr[15:8], sel2 = addr[AWIDTH-1:16] zero-extended to 8 bits, sel3 = rdata.
- **Address writes** (IDLE only, avr_wr with sel 0..2):
  - Load the selected address byte on the next edge.
  - busy stays 0.
  - avr_rd with sel 0..2 has no effect.
- **Data write** (avr_wr, sel=3, IDLE):
  - Latch avr_din into sram_dout and go to SETUP.
- **Data read** (avr_rd, sel=3, IDLE):
  - Go to SETUP with the read flag set.
- **State machine** (IDLE, SETUP, STROBE, HOLD):
  - IDLE: waits for a command.
  - SETUP, 1 cycle: busy=1, ce_n=0, address and data stable.
  - STROBE, WE_CYCLES or OE_CYCLES cycles: ce_n=0 and we_n=0 (write) or oe_n=0 (read).
    - A 4-bit down-counter loads N-1 on entry; the state exits when the counter reaches 0.
  - HOLD, 1 cycle: strobes=1, ce_n=0.
    - For a read, rdata captures sram_din on the STROBE->HOLD edge.
  - HOLD -> IDLE:
    - ce_n=1, busy=0.
    - If AUTOINC=1, addr <= addr+1 modulo 2^AWIDTH, so all-ones wraps to 0.
- **Timing.** For a command sampled at edge 0:
  - busy is high from edge 1 through edge N+2 and low after edge N+3.
  - The strobe is low for exactly N cycles, from edge 2 to edge N+2.
- **Busy rule.** Any avr_wr/avr_rd while busy=1 is ignored, including address writes; addr and sram_dout stay stable during a cycle.
- **Simultaneous avr_wr and avr_rd.** avr_wr wins; avr_rd is dropped.
- **Back-to-back.** A command arriving on the edge busy falls, i.e. the cycle after HOLD, is accepted.
- **Strobe exclusivity.** sram_we_n and sram_oe_n are never low simultaneously; a checker asserts this.

Test Plan:
- **Reset values.** Assert reset for 2 cycles -> all strobes 1, busy 0, addr 0, avr_dout with sel0 = 0x00.
- **Address load, write and increment.**
  - Stimulus: write 0x34/0x12/0x05 to sel0/1/2 (AWIDTH=24), then DATA write 0xA5.
  - Required response: sram_addr=0x051234 during strobe, we_n low exactly 3 cycles, sram_dout=0xA5, busy high 5 cycles, then addr=0x051235.
- **Read.**
  - Stimulus: addr=0x000010, SRAM model returns 0x5A, avr_rd with sel3.
  - Required response: oe_n low 3 cycles, we_n stays 1, after busy falls avr_dout(sel3)=0x5A, addr=0x000011.
- **Wrap-around.** addr=0xFFFFFF, DATA write -> addr becomes 0x000000; readback sel2=0x00.
- **Busy protection and priority.**
  - Stimulus: during a write cycle, pulse avr_wr sel0 with 0xFF and avr_rd sel3.
  - Required response: addr byte unchanged, no second cycle. Simultaneous wr and rd in IDLE performs a write only.
- **Reset mid-strobe and parameters.**
  - Reset while we_n=0 -> we_n=1 and busy=0 at the next edge, addr=0.
  - Repeat write with WE_CYCLES=1 and OE_CYCLES=15 -> strobe widths 1 and 15 cycles.
